// File: rtl/update_seq_pkg.sv
// Shared types and constants for the four-step register update sequencer.
package update_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    STEP_A = 2'd0,
    STEP_D = 2'd1,
    STEP_B = 2'd2,
    STEP_C = 2'd3
  } step_e;

  localparam int SUB_CONST = 3;
  localparam int ADD_CONST = 10;
  localparam int INC_CONST = 1;

endpackage

// File: rtl/update_sequencer_step_timer.sv
// Per-step wait counter: counts 0..STEP_CYCLES-1 while enabled, flags the final cycle.
module step_timer #(
  parameter int STEP_CYCLES = 5
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic last
);

  localparam int CW = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
  localparam logic [CW-1:0] LAST_VAL = CW'(STEP_CYCLES - 1);

  logic [CW-1:0] r_cnt;

  // Wait counter; wraps to zero on the commit cycle so the next step starts fresh.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (clear) begin
      r_cnt <= '0;
    end else if (enable) begin
      if (last) begin
        r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt + CW'(1);
      end
    end else begin
      r_cnt <= r_cnt;
    end
  end

  assign last = (r_cnt == LAST_VAL);

endmodule

// File: rtl/update_sequencer.sv
// Clocked controller for the a<-b+c, d<-a-3, b<-d+10, c<-c+1 update loop,
// with start/busy/done handshake, abort and per-step hold time.
module update_sequencer
  import update_seq_pkg::*;
#(
  parameter int WIDTH       = 32,
  parameter int ITERS       = 4,
  parameter int STEP_CYCLES = 5
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic                       abort,
  input  logic [WIDTH-1:0]           a_init,
  input  logic [WIDTH-1:0]           b_init,
  input  logic [WIDTH-1:0]           c_init,
  input  logic [WIDTH-1:0]           d_init,
  output logic                       busy,
  output logic                       done,
  output logic [1:0]                 step,
  output logic [$clog2(ITERS+1)-1:0] iter,
  output logic [WIDTH-1:0]           a,
  output logic [WIDTH-1:0]           b,
  output logic [WIDTH-1:0]           c,
  output logic [WIDTH-1:0]           d
);

  localparam int IW = $clog2(ITERS + 1);
  localparam logic [IW-1:0] ITER_LAST = IW'(ITERS - 1);

  state_e          r_state;
  state_e          w_state_nxt;
  step_e           r_step;
  logic [IW-1:0]   r_iter;
  logic [WIDTH-1:0] r_a, r_b, r_c, r_d;
  logic            r_busy, r_done;
  logic            w_last, w_load, w_commit, w_run_en;

  // Abort outranks both start and a pending commit.
  assign w_load   = (r_state != ST_RUN) && start && !abort;
  assign w_run_en = (r_state == ST_RUN) && !abort;
  assign w_commit = w_run_en && w_last;

  step_timer #(
    .STEP_CYCLES(STEP_CYCLES)
  ) u_step_timer (
    .clk    (clk),
    .rst    (rst),
    .clear  (w_load),
    .enable (w_run_en),
    .last   (w_last)
  );

  // Next-state decode for IDLE/RUN/DONE.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_load) w_state_nxt = ST_RUN;
        else        w_state_nxt = ST_IDLE;
      end
      ST_RUN: begin
        if (abort)
          w_state_nxt = ST_IDLE;
        else if (w_commit && (r_step == STEP_C) && (r_iter == ITER_LAST))
          w_state_nxt = ST_DONE;
        else
          w_state_nxt = ST_RUN;
      end
      ST_DONE: begin
        if (w_load) w_state_nxt = ST_RUN;
        else        w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // State, handshake flags, and the datapath/iteration registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_step  <= STEP_A;
      r_iter  <= '0;
      r_a     <= '0;
      r_b     <= '0;
      r_c     <= '0;
      r_d     <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_busy  <= (w_state_nxt == ST_RUN);
      r_done  <= (w_state_nxt == ST_DONE);
      if (w_load) begin
        r_a    <= a_init;
        r_b    <= b_init;
        r_c    <= c_init;
        r_d    <= d_init;
        r_iter <= '0;
        r_step <= STEP_A;
      end else if (w_commit) begin
        case (r_step)
          STEP_A: begin
            r_a    <= r_b + r_c;
            r_step <= STEP_D;
          end
          STEP_D: begin
            r_d    <= r_a - WIDTH'(SUB_CONST);
            r_step <= STEP_B;
          end
          STEP_B: begin
            r_b    <= r_d + WIDTH'(ADD_CONST);
            r_step <= STEP_C;
          end
          STEP_C: begin
            r_c    <= r_c + WIDTH'(INC_CONST);
            r_iter <= r_iter + IW'(1);
            r_step <= STEP_A;
          end
          default: r_step <= STEP_A;
        endcase
      end else begin
        r_step <= r_step;
      end
    end
  end

  assign busy = r_busy;
  assign done = r_done;
  assign step = r_step;
  assign iter = r_iter;
  assign a    = r_a;
  assign b    = r_b;
  assign c    = r_c;
  assign d    = r_d;

endmodule

// File: tb/tb_update_sequencer.sv
// Randomized self-checking bench for update_sequencer against a loop-level model.
module tb_update_sequencer;

  localparam int W     = 32;
  localparam int I     = 4;
  localparam int S     = 5;
  localparam int TOTAL = 4 * S * I;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0, abort = 1'b0;
  logic [W-1:0]  a_init = '0, b_init = '0, c_init = '0, d_init = '0;
  logic          busy, done;
  logic [1:0]    step;
  logic [2:0]    iter;
  logic [W-1:0]  a, b, c, d;

  logic          s8_start = 1'b0, s8_abort = 1'b0;
  logic [7:0]    s8_a_init = '0, s8_b_init = '0, s8_c_init = '0, s8_d_init = '0;
  logic          s8_busy, s8_done;
  logic [1:0]    s8_step;
  logic [0:0]    s8_iter;
  logic [7:0]    s8_a, s8_b, s8_c, s8_d;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  update_sequencer #(.WIDTH(W), .ITERS(I), .STEP_CYCLES(S)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .a_init(a_init), .b_init(b_init), .c_init(c_init), .d_init(d_init),
    .busy(busy), .done(done), .step(step), .iter(iter),
    .a(a), .b(b), .c(c), .d(d)
  );

  update_sequencer #(.WIDTH(8), .ITERS(1), .STEP_CYCLES(1)) dut8 (
    .clk(clk), .rst(rst), .start(s8_start), .abort(s8_abort),
    .a_init(s8_a_init), .b_init(s8_b_init), .c_init(s8_c_init), .d_init(s8_d_init),
    .busy(s8_busy), .done(s8_done), .step(s8_step), .iter(s8_iter),
    .a(s8_a), .b(s8_b), .c(s8_c), .d(s8_d)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: apply the first k updates of the loop to the initial values.
  task automatic model(input logic [31:0] ai, bi, ci, di, input int k,
                       output logic [31:0] ea, eb, ec, ed);
    ea = ai; eb = bi; ec = ci; ed = di;
    for (int j = 0; j < k; j++) begin
      case (j % 4)
        0:       ea = eb + ec;
        1:       ed = ea - 32'd3;
        2:       eb = ed + 32'd10;
        default: ec = ec + 32'd1;
      endcase
    end
  endtask

  // One run from IDLE, checked every cycle; abort_at > 0 aborts on that edge.
  task automatic run_check(input logic [31:0] ai, bi, ci, di, input int abort_at);
    logic [31:0] ea, eb, ec, ed;
    int k, dones;
    bit aborted, eb_busy, eb_done;
    a_init = ai; b_init = bi; c_init = ci; d_init = di;
    start = 1'b1;
    tick();
    start = 1'b0;
    checks++;
    if ({busy, a, b, c, d} !== {1'b1, ai, bi, ci, di}) begin
      errors++;
      $display("FAIL load: got busy=%0b a=%0d b=%0d c=%0d d=%0d exp busy=1 a=%0d b=%0d c=%0d d=%0d",
               busy, a, b, c, d, ai, bi, ci, di);
    end
    dones = 0;
    aborted = 1'b0;
    for (int n = 1; n <= TOTAL + 2; n++) begin
      abort = (n == abort_at);
      tick();
      abort = 1'b0;
      if (abort_at > 0 && n >= abort_at) aborted = 1'b1;
      k = aborted ? (abort_at - 1) / S : n / S;
      if (k > 4 * I) k = 4 * I;
      model(ai, bi, ci, di, k, ea, eb, ec, ed);
      eb_busy = !aborted && (n < TOTAL);
      eb_done = !aborted && (n == TOTAL);
      if (done) dones++;
      checks++;
      if ({a, b, c, d} !== {ea, eb, ec, ed}) begin
        errors++;
        $display("FAIL regs n=%0d: got a=%0d b=%0d c=%0d d=%0d exp a=%0d b=%0d c=%0d d=%0d",
                 n, a, b, c, d, ea, eb, ec, ed);
      end
      checks++;
      if ({busy, done, step, iter} !== {eb_busy, eb_done, 2'(k % 4), 3'(k / 4)}) begin
        errors++;
        $display("FAIL ctrl n=%0d: got busy=%0b done=%0b step=%0d iter=%0d exp busy=%0b done=%0b step=%0d iter=%0d",
                 n, busy, done, step, iter, eb_busy, eb_done, k % 4, k / 4);
      end
    end
    checks++;
    if (dones !== ((abort_at > 0) ? 0 : 1)) begin
      errors++;
      $display("FAIL done_count: got %0d exp %0d", dones, (abort_at > 0) ? 0 : 1);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    tick();
    checks++;
    if ({busy, done, step, iter, a, b, c, d} !== '0) begin
      errors++;
      $display("FAIL reset: got busy=%0b done=%0b step=%0d iter=%0d a=%0d b=%0d c=%0d d=%0d exp all zero",
               busy, done, step, iter, a, b, c, d);
    end
  endtask

  task automatic test_wrap8();
    s8_a_init = 8'd0; s8_b_init = 8'd127; s8_c_init = 8'd1; s8_d_init = 8'd0;
    s8_start = 1'b1;
    tick();
    s8_start = 1'b0;
    tick();
    checks++;
    if (s8_a !== 8'h80) begin errors++; $display("FAIL wrap8_a: got %h exp 80", s8_a); end
    tick();
    checks++;
    if (s8_d !== 8'h7D) begin errors++; $display("FAIL wrap8_d: got %h exp 7d", s8_d); end
    tick();
    checks++;
    if (s8_b !== 8'h87) begin errors++; $display("FAIL wrap8_b: got %h exp 87", s8_b); end
    tick();
    checks++;
    if ({s8_c, s8_done, s8_busy, s8_iter} !== {8'h02, 1'b1, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL wrap8_end: got c=%h done=%0b busy=%0b iter=%0d exp c=02 done=1 busy=0 iter=1",
               s8_c, s8_done, s8_busy, s8_iter);
    end
  endtask

  task automatic test_basic_run();
    run_check(32'd30, 32'd20, 32'd15, 32'd5, 0);
    checks++;
    if ({a, d, b, c, iter} !== {32'd107, 32'd104, 32'd114, 32'd19, 3'd4}) begin
      errors++;
      $display("FAIL basic_final: got a=%0d d=%0d b=%0d c=%0d iter=%0d exp 107 104 114 19 4",
               a, d, b, c, iter);
    end
  endtask

  task automatic test_abort();
    run_check(32'd30, 32'd20, 32'd15, 32'd5, 18);
    checks++;
    if ({busy, a, d, b, c, iter} !== {1'b0, 32'd35, 32'd32, 32'd42, 32'd15, 3'd0}) begin
      errors++;
      $display("FAIL abort_frozen: got busy=%0b a=%0d d=%0d b=%0d c=%0d iter=%0d exp 0 35 32 42 15 0",
               busy, a, d, b, c, iter);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] ea, eb, ec, ed;
    int lows;
    a_init = 32'd30; b_init = 32'd20; c_init = 32'd15; d_init = 32'd5;
    start = 1'b1;
    tick();
    lows = 0;
    for (int n = 1; n <= TOTAL + 1; n++) begin
      tick();
      if (!busy) lows++;
      if (n == TOTAL / 2) begin
        model(32'd30, 32'd20, 32'd15, 32'd5, n / S, ea, eb, ec, ed);
        checks++;
        if ({busy, a, b, c, d} !== {1'b1, ea, eb, ec, ed}) begin
          errors++;
          $display("FAIL b2b_mid: got busy=%0b a=%0d b=%0d c=%0d d=%0d exp busy=1 a=%0d b=%0d c=%0d d=%0d",
                   busy, a, b, c, d, ea, eb, ec, ed);
        end
      end
      if (n == TOTAL) begin
        checks++;
        if ({done, busy, c} !== {1'b1, 1'b0, 32'd19}) begin
          errors++;
          $display("FAIL b2b_done: got done=%0b busy=%0b c=%0d exp done=1 busy=0 c=19", done, busy, c);
        end
      end
      if (n == TOTAL + 1) begin
        checks++;
        if ({busy, done, iter, a, b, c, d} !== {1'b1, 1'b0, 3'd0, 32'd30, 32'd20, 32'd15, 32'd5}) begin
          errors++;
          $display("FAIL b2b_reload: got busy=%0b done=%0b iter=%0d a=%0d b=%0d c=%0d d=%0d exp 1 0 0 30 20 15 5",
                   busy, done, iter, a, b, c, d);
        end
      end
    end
    start = 1'b0;
    abort = 1'b1;
    tick();
    abort = 1'b0;
    checks++;
    if (lows !== 1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL b2b_gap: got low_cycles=%0d busy=%0b exp low_cycles=1 busy=0", lows, busy);
    end
  endtask

  task automatic test_async_reset();
    a_init = $urandom; b_init = $urandom; c_init = $urandom; d_init = $urandom;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int n = 0; n < 12; n++) tick();
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if ({busy, done, step, iter, a, b, c, d} !== '0) begin
      errors++;
      $display("FAIL async_reset: got busy=%0b done=%0b step=%0d iter=%0d a=%0d b=%0d c=%0d d=%0d exp all zero",
               busy, done, step, iter, a, b, c, d);
    end
    tick();
    rst = 1'b0;
    tick();
    run_check($urandom, $urandom, $urandom, $urandom, 0);
  endtask

  task automatic test_start_abort_idle();
    logic [31:0] held_a;
    held_a = a;
    a_init = held_a + 32'd1; b_init = 32'd2; c_init = 32'd3; d_init = 32'd4;
    start = 1'b1;
    abort = 1'b1;
    tick();
    start = 1'b0;
    abort = 1'b0;
    tick();
    checks++;
    if ({busy, done, a} !== {1'b0, 1'b0, held_a}) begin
      errors++;
      $display("FAIL start_abort_idle: got busy=%0b done=%0b a=%0d exp busy=0 done=0 a=%0d",
               busy, done, a, held_a);
    end
  endtask

  task automatic test_random();
    for (int r = 0; r < 3; r++) begin
      run_check($urandom, $urandom, $urandom, $urandom,
                (r == 1) ? int'($urandom_range(1, TOTAL - 1)) : 0);
    end
  endtask

  initial begin
    test_reset();
    test_wrap8();
    test_basic_run();
    test_abort();
    test_back_to_back();
    test_start_abort_idle();
    test_async_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
